mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Main-memory side of the cache subsystem. Sits directly downstream of the cache controller FSM and services its `MStrobe`/`MRW` requests. Reads are line fills: after a fixed access latency it returns a 4-word burst, one word per cycle, for the cache data array to capture. Writes are single-word write-through commits. Both complete with a one-cycle `MRdy` pulse.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W words.
- `DATA_W`, 32: word width.
- `WAIT_CYC`, 3: access latency in cycles, legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `MStrobe`  in  1  request valid from the cache FSM.
- `MRW`  in  1  request type: 1 = write, 0 = read (line fill).
- `MAddr`  in  ADDR_W  word address; bits [1:0] are ignored on reads.
- `MDataIn`  in  DATA_W  write data.
- `MDataOut`  out  DATA_W  read burst data; 0 whenever `MValid`=0.
- `MValid`  out  1  `MDataOut` holds a burst word this cycle.
- `MWordIdx`  out  2  word offset within the line of the current burst word.
- `MRdy`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high when the block is not in IDLE.

## Operation
- Storage is an internal array of 2^ADDR_W x DATA_W words.
  - The array is not cleared by reset.
  - Contents are undefined until written.
- States and transitions:
  - IDLE, WAIT, BURST, DONE.
  - IDLE -> WAIT when `MStrobe`=1 is sampled. On that edge the block latches `MRW`, `MAddr` and `MDataIn`.
  - Read requests latch the line base `{MAddr[ADDR_W-1:2],2'b00}`.
  - WAIT holds for `WAIT_CYC` cycles, counted by a 4-bit down-counter loaded with `WAIT_CYC-1`.
  - WAIT -> BURST (read) or WAIT -> DONE (write) when the counter reaches 0.
- Write commit: the array is written with the latched data at the latched address on the edge that leaves WAIT.
- BURST lasts exactly 4 cycles, with a 2-bit index running 0,1,2,3.
  - Each cycle: `MValid`=1, `MWordIdx`=index, `MDataOut`=array[base+index].
  - The index wraps within the line. It never carries into address bits [ADDR_W-1:2], so base 0xFC reads 0xFC..0xFF.
  - BURST -> DONE after index 3.
- DONE: `MRdy`=1 for exactly this cycle, then -> IDLE unconditionally.
- `MStrobe` sampled in any state other than IDLE is ignored. There is no queueing, and input changes while busy have no effect.
- `Busy`=1 in WAIT, BURST and DONE.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Timing
- Reset: `reset_n`=0 at a rising edge forces the following on the next cycle, regardless of the current state:
  - state IDLE;
  - `MDataOut`=0, `MValid`=0, `MWordIdx`=0, `MRdy`=0, `Busy`=0;
  - counter=0.
- Reset mid-burst or mid-wait aborts the request with no `MRdy`.
- A write aborted in WAIT before its commit edge leaves the array unchanged.
- The strobe is sampled at edge T (block in IDLE).
- Read timing:
  - WAIT occupies cycles T+1..T+`WAIT_CYC`.
  - Burst words appear in cycles T+`WAIT_CYC`+1..T+`WAIT_CYC`+4.
  - `MRdy` is high in cycle T+`WAIT_CYC`+5.
  - IDLE is reached at T+`WAIT_CYC`+6.
- Write timing:
  - WAIT occupies cycles T+1..T+`WAIT_CYC`.
  - The array is updated at the end of T+`WAIT_CYC`.
  - `MRdy` is high in cycle T+`WAIT_CYC`+1.
- Back-to-back requests: a new strobe is accepted no earlier than the first IDLE cycle after DONE. The minimum request spacing is therefore `WAIT_CYC`+6 cycles for reads and `WAIT_CYC`+2 for writes.
- Read-after-write: a write always commits before the next request can be accepted, so a subsequent read returns the new data.
- `MRdy` and `MValid` are never high in the same cycle.

## Test plan
- Reset: run a read, assert `reset_n`=0 during BURST word 1 → next cycle all outputs are 0 and `Busy`=0; no `MRdy` follows.
- Write then fill (`WAIT_CYC`=3):
  - Stimulus: write 0xA0A0_0000+i to addresses 0x10..0x13 (4 writes), then read `MAddr`=0x12.
  - Each write returns `MRdy` 4 cycles after its strobe edge.
  - The read returns words 0xA0A0_0000..0xA0A0_0003 with `MWordIdx` 0..3 in cycles T+4..T+7, and `MRdy` at T+8.
- Top-of-memory wrap:
  - Stimulus: write distinct values to 0xFC..0xFF and 0x00, then read `MAddr`=0xFF.
  - Required response: the burst returns 0xFC..0xFF data in order; address 0x00 is never read.
- Ignored strobe: hold `MStrobe`=1 with `MRW`=1, `MAddr`=0x40 throughout a read burst → array[0x40] is unchanged, and exactly one `MRdy` is seen for the read.
- Latency sweep: `WAIT_CYC`=1 and 15.
  - Read `MRdy` lands at T+6 and T+20.
  - Write `MRdy` lands at T+2 and T+16.
  - `Busy` is high exactly from T+1 through the `MRdy` cycle.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Main-memory model for the cache subsystem: fixed-latency 4-word line fills
// and single-word write-through commits, each finished by a one-cycle MRdy.
module mem_burst_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MValid,
  output logic [1:0]        MWordIdx,
  output logic              MRdy,
  output logic              Busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic [1:0]          widx_q, widx_d;
  logic                rdy_q, rdy_d;
  logic                mem_we;
  logic [1:0]          idx_nxt;
  logic [ADDR_W-3:0]   line_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  assign idx_nxt = idx_q + 2'd1;
  assign line_q  = addr_q[ADDR_W-1:2];

  // Burst words are fetched one cycle ahead so MDataOut comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = '0;
    valid_d = 1'b0;
    widx_d  = '0;
    rdy_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MStrobe) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
          idx_d   = '0;
          rw_d    = MRW;
          addr_d  = MRW ? MAddr : {MAddr[ADDR_W-1:2], 2'b00};
          wdata_d = MDataIn;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (rw_q) begin
            mem_we  = 1'b1;
            state_d = S_DONE;
            rdy_d   = 1'b1;
          end else begin
            state_d = S_BURST;
            idx_d   = '0;
            valid_d = 1'b1;
            widx_d  = '0;
            dout_d  = mem_q[{line_q, 2'b00}];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
        end else begin
          idx_d   = idx_nxt;
          valid_d = 1'b1;
          widx_d  = idx_nxt;
          dout_d  = mem_q[{line_q, idx_nxt}];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      widx_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      widx_q  <= widx_d;
      rdy_q   <= rdy_d;
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign MDataOut = dout_q;
  assign MValid   = valid_q;
  assign MWordIdx = widx_q;
  assign MRdy     = rdy_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: reset abort, write/fill, line wrap,
// ignored strobes, and latency sweep on WAIT_CYC=1 and 15 instances.
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MStrobe, s1, s15;
  logic        MRW;
  logic [7:0]  MAddr;
  logic [31:0] MDataIn;

  logic [31:0] MDataOut, dout1, dout15;
  logic        MValid, val1, val15;
  logic [1:0]  MWordIdx, widx1, widx15;
  logic        MRdy, rdy1, rdy15;
  logic        Busy, busy1, busy15;

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_seen = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(MDataOut), .MValid(MValid), .MWordIdx(MWordIdx),
    .MRdy(MRdy), .Busy(Busy));

  mem_burst_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .MStrobe(s1), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(dout1), .MValid(val1), .MWordIdx(widx1),
    .MRdy(rdy1), .Busy(busy1));

  mem_burst_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(15)) u_w15 (
    .clk(clk), .reset_n(reset_n), .MStrobe(s15), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(dout15), .MValid(val15), .MWordIdx(widx15),
    .MRdy(rdy15), .Busy(busy15));

  always @(negedge clk) begin
    if (MRdy === 1'b1) rdy_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int cyc;
    MRW = 1'b1; MAddr = a; MDataIn = d; MStrobe = 1'b1;
    tick;
    MStrobe = 1'b0;
    cyc = 1;
    while (MRdy !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    chk($sformatf("wr%0h_lat", a), cyc, 4);
    tick;
  endtask

  // hold=1 keeps a write strobe to 0x40 asserted for the whole read
  task automatic do_read(input logic [7:0] a, input logic hold,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    int cyc;
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    MRW = 1'b0; MAddr = a; MDataIn = 32'h0; MStrobe = 1'b1;
    tick;
    if (hold) begin
      MRW = 1'b1; MAddr = 8'h40; MDataIn = 32'hDEAD_BEEF;
    end else begin
      MStrobe = 1'b0;
    end
    cyc = 1;
    while (MValid !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    chk($sformatf("rd%0h_first_word_lat", a), cyc, 4);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("rd%0h_w%0d_valid", a, w), MValid, 1);
      chk($sformatf("rd%0h_w%0d_idx", a, w), MWordIdx, w);
      chk($sformatf("rd%0h_w%0d_data", a, w), MDataOut, ev[w]);
      chk($sformatf("rd%0h_w%0d_nordy", a, w), MRdy, 0);
      tick;
    end
    chk($sformatf("rd%0h_rdy", a), MRdy, 1);
    chk($sformatf("rd%0h_rdy_novalid", a), MValid, 0);
    chk($sformatf("rd%0h_rdy_dout0", a), MDataOut, 0);
    MStrobe = 1'b0;
    tick;
    chk($sformatf("rd%0h_idle", a), Busy, 0);
  endtask

  function automatic logic sw_busy(input int sel);
    return (sel == 1) ? busy1 : busy15;
  endfunction

  function automatic logic sw_rdy(input int sel);
    return (sel == 1) ? rdy1 : rdy15;
  endfunction

  task automatic sweep(input int sel, input logic rw, input logic [7:0] a,
                       input int want_lat, input string tag);
    int cyc;
    int busy_bad;
    MRW = rw; MAddr = a; MDataIn = 32'h5A5A_0000 + 32'(a);
    if (sel == 1) s1 = 1'b1; else s15 = 1'b1;
    tick;
    s1 = 1'b0; s15 = 1'b0;
    cyc = 1;
    busy_bad = 0;
    while (cyc < 60) begin
      if (sw_busy(sel) !== 1'b1) busy_bad++;
      if (sw_rdy(sel) === 1'b1) break;
      tick;
      cyc++;
    end
    chk({tag, "_rdy_lat"}, cyc, want_lat);
    chk({tag, "_busy_window"}, busy_bad, 0);
    tick;
    chk({tag, "_idle_after"}, sw_busy(sel), 0);
  endtask

  initial begin
    int cyc;
    int r0;
    reset_n = 1'b0; MStrobe = 1'b0; s1 = 1'b0; s15 = 1'b0;
    MRW = 1'b0; MAddr = 8'h0; MDataIn = 32'h0;
    repeat (3) tick;
    chk("rst_dout", MDataOut, 0);
    chk("rst_valid", MValid, 0);
    chk("rst_widx", MWordIdx, 0);
    chk("rst_rdy", MRdy, 0);
    chk("rst_busy", Busy, 0);
    reset_n = 1'b1;
    tick;

    // Read aborted by reset during burst word 1
    MRW = 1'b0; MAddr = 8'h20; MStrobe = 1'b1;
    tick;
    MStrobe = 1'b0;
    cyc = 1;
    while (MValid !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    chk("abort_rd_first_lat", cyc, 4);
    tick;
    chk("abort_rd_word1_idx", MWordIdx, 1);
    reset_n = 1'b0;
    tick;
    chk("abort_rd_dout", MDataOut, 0);
    chk("abort_rd_valid", MValid, 0);
    chk("abort_rd_widx", MWordIdx, 0);
    chk("abort_rd_rdy", MRdy, 0);
    chk("abort_rd_busy", Busy, 0);
    reset_n = 1'b1;
    r0 = rdy_seen;
    repeat (12) tick;
    chk("abort_rd_no_rdy", rdy_seen - r0, 0);

    for (int i = 0; i < 4; i++) do_write(8'h10 + 8'(i), 32'hA0A0_0000 + 32'(i));

    // Write to 0x11 aborted in its first WAIT cycle must not commit
    MRW = 1'b1; MAddr = 8'h11; MDataIn = 32'hDEAD_0011; MStrobe = 1'b1;
    tick;
    MStrobe = 1'b0;
    chk("abort_wr_busy", Busy, 1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    do_read(8'h10, 1'b0, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003);
    do_read(8'h12, 1'b0, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003);

    // Top-of-memory line: index must not carry into 0x00
    do_write(8'hFC, 32'hF0F0_00FC);
    do_write(8'hFD, 32'hF0F0_00FD);
    do_write(8'hFE, 32'hF0F0_00FE);
    do_write(8'hFF, 32'hF0F0_00FF);
    do_write(8'h00, 32'h0000_0BAD);
    do_read(8'hFF, 1'b0, 32'hF0F0_00FC, 32'hF0F0_00FD, 32'hF0F0_00FE, 32'hF0F0_00FF);

    // Strobe held as a write to 0x40 during a read is ignored
    for (int i = 0; i < 4; i++) do_write(8'h40 + 8'(i), 32'h4040_0040 + 32'(i));
    r0 = rdy_seen;
    do_read(8'h13, 1'b1, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003);
    repeat (4) tick;
    chk("ignored_strobe_one_rdy", rdy_seen - r0, 1);
    do_read(8'h40, 1'b0, 32'h4040_0040, 32'h4040_0041, 32'h4040_0042, 32'h4040_0043);

    // Latency sweep
    sweep(1, 1'b1, 8'h55, 2, "w1_write");
    sweep(1, 1'b0, 8'h55, 6, "w1_read");
    sweep(15, 1'b1, 8'h55, 16, "w15_write");
    sweep(15, 1'b0, 8'h55, 20, "w15_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
